// File: rtl/ir_key_ctrl.sv
// NEC remote-control key controller: validates decoded frames, tracks held keys,
// generates auto-repeat events and maintains a six-digit BCD entry buffer.
module ir_key_ctrl #(
    parameter logic [7:0] CUST_ADDR  = 8'h00,
    parameter int         HOLD_TO_MS = 110,
    parameter int         REP_DLY    = 4,
    parameter int         REP_DIV    = 2,
    parameter logic [7:0] CLR_CODE   = 8'h45,
    parameter logic [7:0] BS_CODE    = 8'h44
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_frame_vld,
    input  logic [31:0] i_frame,
    input  logic        i_repeat,
    input  logic        i_tick_1ms,
    output logic        o_key_vld,
    output logic [7:0]  o_key,
    output logic        o_key_rpt,
    output logic        o_err,
    output logic [7:0]  o_err_cnt,
    output logic [23:0] o_digits,
    output logic        o_held
);

    localparam logic [7:0] HOLD_TO_B = 8'(HOLD_TO_MS);
    localparam logic [7:0] REP_DLY_B = 8'(REP_DLY);
    localparam logic [7:0] REP_DIV_B = 8'(REP_DIV);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] frame_q, frame_d;
    logic [7:0]  hold_tmr_q, hold_tmr_d;
    logic [7:0]  rpt_cnt_q, rpt_cnt_d;
    logic        key_vld_q, key_vld_d;
    logic [7:0]  key_q, key_d;
    logic        key_rpt_q, key_rpt_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [23:0] digits_q, digits_d;
    logic        held_q, held_d;

    logic [7:0]  f_addr, f_addr_n, f_cmd, f_cmd_n;
    logic        frame_ok;
    logic [7:0]  rpt_cnt_inc;
    logic [7:0]  tmr_inc;
    logic        hold_repeat;
    logic        auto_fire;
    logic [1:0]  n_err;
    logic [8:0]  err_sum;

    assign f_addr      = frame_q[31:24];
    assign f_addr_n    = frame_q[23:16];
    assign f_cmd       = frame_q[15:8];
    assign f_cmd_n     = frame_q[7:0];
    assign frame_ok    = (f_addr == CUST_ADDR) && ((f_addr ^ f_addr_n) == 8'hFF)
                         && ((f_cmd ^ f_cmd_n) == 8'hFF);
    assign rpt_cnt_inc = (rpt_cnt_q == 8'hFF) ? 8'hFF : rpt_cnt_q + 8'd1;
    assign tmr_inc     = hold_tmr_q + 8'd1;
    // A frame arriving together with a repeat takes precedence over it.
    assign hold_repeat = (state_q == S_HOLD) && i_repeat && !i_frame_vld;
    assign auto_fire   = hold_repeat && (rpt_cnt_inc >= REP_DLY_B)
                         && (((rpt_cnt_inc - REP_DLY_B) % REP_DIV_B) == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            hold_tmr_q <= '0;
            rpt_cnt_q  <= '0;
            key_vld_q  <= 1'b0;
            key_q      <= '0;
            key_rpt_q  <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            digits_q   <= '0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            hold_tmr_q <= hold_tmr_d;
            rpt_cnt_q  <= rpt_cnt_d;
            key_vld_q  <= key_vld_d;
            key_q      <= key_d;
            key_rpt_q  <= key_rpt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            digits_q   <= digits_d;
            held_q     <= held_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        hold_tmr_d = hold_tmr_q;
        rpt_cnt_d  = rpt_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_frame_vld) begin
                    frame_d = i_frame;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (frame_ok) begin
                    state_d    = S_HOLD;
                    hold_tmr_d = '0;
                    rpt_cnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (i_frame_vld) begin
                    frame_d = i_frame;
                    state_d = S_CHECK;
                end else if (i_repeat) begin
                    hold_tmr_d = '0;
                    rpt_cnt_d  = rpt_cnt_inc;
                end else if (i_tick_1ms) begin
                    hold_tmr_d = tmr_inc;
                    if (tmr_inc == HOLD_TO_B) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        key_vld_d = 1'b0;
        key_d     = key_q;
        key_rpt_d = key_rpt_q;
        err_d     = 1'b0;
        digits_d  = digits_q;
        held_d    = (state_d == S_HOLD);
        // The checked frame and a frame dropped during CHECK can both count.
        n_err     = {1'b0, (state_q == S_CHECK) && !frame_ok}
                    + {1'b0, (state_q == S_CHECK) && i_frame_vld};
        err_sum   = {1'b0, err_cnt_q} + {7'b0, n_err};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        if (n_err != 2'd0) begin
            err_d = 1'b1;
        end
        if ((state_q == S_CHECK) && frame_ok) begin
            key_vld_d = 1'b1;
            key_d     = f_cmd;
            key_rpt_d = 1'b0;
            if (f_cmd <= 8'h09) begin
                digits_d = {digits_q[19:0], f_cmd[3:0]};
            end else if (f_cmd == CLR_CODE) begin
                digits_d = '0;
            end else if (f_cmd == BS_CODE) begin
                digits_d = {4'h0, digits_q[23:4]};
            end
        end else if (auto_fire) begin
            key_vld_d = 1'b1;
            key_rpt_d = 1'b1;
        end
    end

    assign o_key_vld = key_vld_q;
    assign o_key     = key_q;
    assign o_key_rpt = key_rpt_q;
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;
    assign o_digits  = digits_q;
    assign o_held    = held_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Self-checking bench for ir_key_ctrl: directed scenarios plus random traffic
// checked against a transaction-level model of the key controller.
module tb_ir_key_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_frame_vld = 1'b0;
    logic [31:0] i_frame = '0;
    logic        i_repeat = 1'b0;
    logic        i_tick_1ms = 1'b0;
    logic        o_key_vld;
    logic [7:0]  o_key;
    logic        o_key_rpt;
    logic        o_err;
    logic [7:0]  o_err_cnt;
    logic [23:0] o_digits;
    logic        o_held;

    int tests = 0;
    int fails = 0;

    // Transaction-level model state
    bit       m_held;
    int       m_key;
    int       m_rpts;
    int       m_ms;
    int       m_digits;
    int       m_errs;

    always #10 clk = ~clk;

    ir_key_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_frame_vld(i_frame_vld),
        .i_frame    (i_frame),
        .i_repeat   (i_repeat),
        .i_tick_1ms (i_tick_1ms),
        .o_key_vld  (o_key_vld),
        .o_key      (o_key),
        .o_key_rpt  (o_key_rpt),
        .o_err      (o_err),
        .o_err_cnt  (o_err_cnt),
        .o_digits   (o_digits),
        .o_held     (o_held)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_key = 0; m_rpts = 0; m_ms = 0; m_digits = 0; m_errs = 0;
    endtask

    function automatic bit frame_good(input logic [31:0] f);
        return (f[31:24] == 8'h00) && (f[31:24] == ~f[23:16]) && (f[15:8] == ~f[7:0]);
    endfunction

    function automatic logic [31:0] mk_frame(input logic [7:0] cmd);
        return {8'h00, 8'hFF, cmd, ~cmd};
    endfunction

    // Applies a frame press to the model; returns whether it is accepted.
    function automatic bit model_frame(input logic [31:0] f);
        int cmd;
        if (!frame_good(f)) begin
            m_errs = (m_errs < 255) ? m_errs + 1 : 255;
            m_held = 0;
            return 0;
        end
        cmd = f[15:8];
        m_key = cmd; m_held = 1; m_rpts = 0; m_ms = 0;
        if (cmd <= 9) m_digits = ((m_digits * 16) + cmd) % (1 << 24);
        else if (cmd == 'h45) m_digits = 0;
        else if (cmd == 'h44) m_digits = m_digits / 16;
        return 1;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_digits"}, o_digits, m_digits);
        chk({tag, "_held"}, o_held, m_held);
        chk({tag, "_errcnt"}, o_err_cnt, m_errs);
    endtask

    task automatic send_frame(input logic [31:0] f, input bit with_rep);
        bit ok;
        @(posedge clk); #1;
        i_frame = f; i_frame_vld = 1'b1; i_repeat = with_rep;
        @(posedge clk); #1;
        i_frame_vld = 1'b0; i_repeat = 1'b0;
        chk("lat_key_vld", o_key_vld, 0);
        chk("lat_err", o_err, 0);
        ok = model_frame(f);
        @(posedge clk); #1;
        chk("frm_key_vld", o_key_vld, ok);
        chk("frm_err", o_err, !ok);
        if (ok) begin
            chk("frm_key", o_key, m_key);
            chk("frm_rpt", o_key_rpt, 0);
        end
        check_state("frm");
        $display("[TB] frame %08h ok=%0d key=%02h digits=%06h errs=%0d", f, ok, o_key, o_digits, o_err_cnt);
    endtask

    task automatic send_repeat();
        bit fire = 0;
        @(posedge clk); #1;
        i_repeat = 1'b1;
        @(posedge clk); #1;
        i_repeat = 1'b0;
        if (m_held) begin
            m_rpts = (m_rpts < 255) ? m_rpts + 1 : 255;
            m_ms = 0;
            fire = (m_rpts >= 4) && ((m_rpts - 4) % 2 == 0);
        end
        chk("rep_key_vld", o_key_vld, fire);
        if (fire) begin
            chk("rep_rpt", o_key_rpt, 1);
            chk("rep_key", o_key, m_key);
        end
        check_state("rep");
        $display("[TB] repeat #%0d fire=%0d key_vld=%0d", m_rpts, fire, o_key_vld);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            i_tick_1ms = 1'b1;
            @(posedge clk); #1;
            i_tick_1ms = 1'b0;
            if (m_held) begin
                m_ms++;
                if (m_ms == 110) m_held = 0;
            end
            if (o_held !== m_held || o_key_vld !== 1'b0) begin
                chk("tick_held", o_held, m_held);
                chk("tick_key_vld", o_key_vld, 0);
            end
        end
        chk("ticks_held", o_held, m_held);
        $display("[TB] %0d ticks held=%0d", n, o_held);
    endtask

    logic [31:0] rf;
    logic [7:0]  rc;

    initial begin
        model_reset();
        #25;
        chk("rst_key_vld", o_key_vld, 0);
        chk("rst_key", o_key, 0);
        chk("rst_err", o_err, 0);
        check_state("rst");
        rst_n = 1'b1;

        // Basic accept and reject
        send_frame(32'h00FF_07F8, 0);
        send_frame(32'h00FF_07F7, 0);
        chk("bad_key_held", o_key, 8'h07);

        // Digit entry, backspace, clear
        for (int d = 1; d <= 7; d++) send_frame(mk_frame(8'(d)), 0);
        chk("dig7", o_digits, 24'h234567);
        send_frame(mk_frame(8'h44), 0);
        chk("dig_bs", o_digits, 24'h023456);
        send_frame(mk_frame(8'h45), 0);
        chk("dig_clr", o_digits, 24'h000000);

        // Held key with repeats every 108 ms
        send_frame(mk_frame(8'h03), 0);
        for (int r = 0; r < 8; r++) begin
            ticks(108);
            send_repeat();
        end

        // Timeout, then a late repeat is ignored
        send_frame(mk_frame(8'h20), 0);
        ticks(109);
        chk("to_held_109", o_held, 1);
        ticks(1);
        chk("to_held_110", o_held, 0);
        send_repeat();

        // Frame and repeat together in HOLD: frame wins, count restarts
        send_frame(mk_frame(8'h05), 0);
        send_frame(mk_frame(8'h06), 1);
        for (int r = 0; r < 4; r++) send_repeat();

        // Second frame while in CHECK is dropped with an error
        @(posedge clk); #1;
        i_frame = mk_frame(8'h08); i_frame_vld = 1'b1;
        @(posedge clk); #1;
        i_frame = mk_frame(8'h09);
        @(posedge clk); #1;
        i_frame_vld = 1'b0;
        void'(model_frame(mk_frame(8'h08)));
        m_errs++;
        chk("drop_key_vld", o_key_vld, 1);
        chk("drop_key", o_key, 8'h08);
        chk("drop_err", o_err, 1);
        check_state("drop");
        @(posedge clk); #1;
        chk("drop_after_vld", o_key_vld, 0);
        chk("drop_after_err", o_err, 0);
        $display("[TB] dropped frame errs=%0d", o_err_cnt);

        // Random traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    case ($urandom_range(0, 3))
                        0: rc = 8'h44;
                        1: rc = 8'h45;
                        2: rc = 8'($urandom);
                        default: rc = 8'($urandom_range(0, 9));
                    endcase
                    rf = mk_frame(rc);
                    if ($urandom_range(0, 3) == 0) rf = rf ^ (32'h1 << $urandom_range(0, 31));
                    send_frame(rf, $urandom_range(0, 1) == 1);
                end
                2: for (int r = 0; r < int'($urandom_range(1, 5)); r++) send_repeat();
                default: ticks($urandom_range(1, 60));
            endcase
        end

        // Reset during CHECK discards the pending frame
        @(posedge clk); #1;
        i_frame = mk_frame(8'h02); i_frame_vld = 1'b1;
        @(posedge clk); #1;
        i_frame_vld = 1'b0;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("rstc_key_vld", o_key_vld, 0);
            chk("rstc_err", o_err, 0);
        end
        check_state("rstc");
        $display("[TB] reset mid-check key_vld=%0d held=%0d", o_key_vld, o_held);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ir_key_ctrl.md
IR_KEY_CTRL -- requirements
Module: ir_key_ctrl

Interface
REQ-001 SHALL have parameter CUST_ADDR, default 8'h00, expected NEC custom (address) byte.
REQ-002 SHALL have parameter HOLD_TO_MS, default 110, ms without repeat before a held key is released.
REQ-003 SHALL have parameter REP_DLY, default 4, repeat codes before auto-repeat starts.
REQ-004 SHALL have parameter REP_DIV, default 2, repeat codes per auto-repeat event once started.
REQ-005 SHALL have parameter CLR_CODE, default 8'h45, command clearing the digit buffer.
REQ-006 SHALL have parameter BS_CODE, default 8'h44, command deleting the last digit.
REQ-007 clk  in  1  system clock, 50 MHz.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 i_frame_vld  in  1  one-cycle strobe, i_frame valid.
REQ-010 i_frame  in  32  NEC frame: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
REQ-011 i_repeat  in  1  one-cycle strobe, NEC repeat code detected.
REQ-012 i_tick_1ms  in  1  one-cycle strobe every 1 ms.
REQ-013 o_key_vld  out  1  one-cycle strobe, o_key valid.
REQ-014 o_key  out  8  accepted command byte, held until next o_key_vld.
REQ-015 o_key_rpt  out  1  qualifies o_key_vld: 1 = auto-repeat event, 0 = fresh press.
REQ-016 o_err  out  1  one-cycle strobe, frame rejected.
REQ-017 o_err_cnt  out  8  rejected-frame count, saturating at 255.
REQ-018 o_digits  out  24  six BCD digits; [3:0] = newest.
REQ-019 o_held  out  1  high while in HOLD.

Function
REQ-020 SHALL implement FSM states IDLE, CHECK, HOLD; all outputs registered.
REQ-021 IDLE/HOLD + i_frame_vld: capture i_frame, go to CHECK next cycle.
REQ-022 CHECK (one cycle): frame valid iff addr==CUST_ADDR, addr^~addr==8'hFF, cmd^~cmd==8'hFF.
REQ-023 Valid frame: o_key_vld=1, o_key=cmd, o_key_rpt=0 the cycle after CHECK (i_frame_vld at N -> o_key_vld at N+2); go to HOLD; clear hold timer and repeat count.
REQ-024 Invalid frame: o_err=1 at N+2, o_err_cnt+1 (saturating); go to IDLE; o_key unchanged.
REQ-025 i_frame_vld while in CHECK: dropped, o_err pulsed, o_err_cnt incremented.
REQ-026 HOLD: hold timer (8-bit) increments on i_tick_1ms; on reaching HOLD_TO_MS -> IDLE, o_held=0.
REQ-027 HOLD + i_repeat: clear hold timer; increment repeat count (8-bit, saturating).
REQ-028 Auto-repeat: when repeat count >= REP_DLY and (count-REP_DLY) % REP_DIV == 0, pulse o_key_vld with same o_key, o_key_rpt=1, one cycle after i_repeat.
REQ-029 i_repeat in IDLE or CHECK: ignored, no error.
REQ-030 Same-cycle i_frame_vld and i_repeat: frame wins, repeat discarded.
REQ-031 Same-cycle i_tick_1ms and i_repeat in HOLD: timer cleared (repeat wins).
REQ-032 Digit buffer updates only on fresh presses (o_key_rpt=0).
REQ-033 Digit update, cmd 0x00-0x09: o_digits <= {o_digits[19:0], cmd[3:0]}; oldest digit dropped.
REQ-034 cmd==CLR_CODE: o_digits <= 0; cmd==BS_CODE: o_digits <= {4'h0, o_digits[23:4]}.
REQ-035 Other cmd values: o_key_vld only, o_digits unchanged.
REQ-036 Digit update takes effect in the same cycle o_key_vld is asserted.

Reset
REQ-037 rst_n low: state IDLE; o_key_vld, o_key_rpt, o_err, o_held = 0; o_key = 0; o_err_cnt = 0; o_digits = 0; timers cleared.
REQ-038 Reset asserted mid-CHECK or mid-HOLD: pending frame discarded, no strobe after release.

Verification
REQ-039 Frame 32'h00FF_07F8 at N -> o_key_vld at N+2, o_key=8'h07, o_key_rpt=0, o_digits=24'h000007, o_held=1.
REQ-040 Frame 32'h00FF_07F7 (bad ~cmd) -> o_err at N+2, o_err_cnt=1, o_key_vld stays 0, state IDLE.
REQ-041 Digits 1,2,3,4,5,6,7 -> o_digits=24'h234567; then BS_CODE frame -> 24'h023456; CLR_CODE frame -> 24'h000000.
REQ-042 Valid press, then i_repeat every 108 ms x8 -> auto-repeat strobes on repeats 4,6,8 with o_key_rpt=1; o_digits unchanged.
REQ-043 Valid press, no repeats -> o_held falls after 110 i_tick_1ms pulses; later i_repeat -> no output.
REQ-044 i_frame_vld and i_repeat same cycle in HOLD -> only fresh-press o_key_vld; repeat count=0.
